// File: rtl/draw_layer_arbiter.sv
// Per-pixel layer arbiter for the RGB332 VGA output.
// Picks the highest-priority opaque layer (index 0 first), otherwise the
// background colour, and registers it. Flags per-pixel overlaps between layers
// and with the bracket border lines, accumulates them over a frame, and
// publishes the totals at every startOfFrame.
module draw_layer_arbiter #(
  parameter int         NUM_LAYERS  = 4,
  parameter logic [7:0] TRANSPARENT = 8'hFF,
  parameter int         CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    startOfFrame,
  input  logic [NUM_LAYERS-1:0]   layer_req,
  input  logic [NUM_LAYERS*8-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]   layer_en,
  input  logic [7:0]              BG_RGB,
  input  logic                    boardersDrawReq,
  output logic [7:0]              RGBOut,
  output logic [NUM_LAYERS-1:0]   layer_hit,
  output logic [NUM_LAYERS-1:0]   frame_hits,
  output logic [CNT_W-1:0]        frame_hit_cnt,
  output logic                    frame_valid
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // True when at least two bits of the vector are set.
  function automatic logic two_or_more(input logic [NUM_LAYERS-1:0] v);
    logic seen_one;
    logic seen_two;
    seen_one = 1'b0;
    seen_two = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (v[i]) begin
        if (seen_one) seen_two = 1'b1;
        seen_one = 1'b1;
      end
    end
    return seen_two;
  endfunction

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  logic [NUM_LAYERS-1:0] eff;
  logic [NUM_LAYERS-1:0] hit;
  logic [7:0]            sel_rgb;

  logic [7:0]            rgb_q;
  logic [NUM_LAYERS-1:0] hit_q;
  logic [NUM_LAYERS-1:0] acc_flags_q;
  logic [CNT_W-1:0]      acc_cnt_q;
  logic [NUM_LAYERS-1:0] frame_hits_q;
  logic [CNT_W-1:0]      frame_cnt_q;
  logic                  frame_valid_q;

  // Effective requests, priority winner and per-pixel collision flags.
  always_comb begin
    eff     = '0;
    hit     = '0;
    sel_rgb = BG_RGB;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      eff[i] = layer_req[i] & layer_en[i] & (layer_rgb[i*8 +: 8] != TRANSPARENT);
    end
    // Walk from lowest priority upward so the lowest active index wins.
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (eff[i]) sel_rgb = layer_rgb[i*8 +: 8];
    end
    hit = eff & {NUM_LAYERS{two_or_more(eff) | boardersDrawReq}};
  end

  // Output register stage plus frame accumulator and publication.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q         <= '0;
      hit_q         <= '0;
      acc_flags_q   <= '0;
      acc_cnt_q     <= '0;
      frame_hits_q  <= '0;
      frame_cnt_q   <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      rgb_q <= sel_rgb;
      hit_q <= hit;
      if (startOfFrame) begin
        // Publish the closing frame; this cycle's hits seed the new one.
        frame_hits_q  <= acc_flags_q;
        frame_cnt_q   <= acc_cnt_q;
        acc_flags_q   <= hit;
        acc_cnt_q     <= (|hit) ? CNT_ONE : '0;
        frame_valid_q <= 1'b1;
      end else begin
        acc_flags_q   <= acc_flags_q | hit;
        acc_cnt_q     <= (|hit) ? sat_inc(acc_cnt_q) : acc_cnt_q;
        frame_valid_q <= 1'b0;
      end
    end
  end

  assign RGBOut        = rgb_q;
  assign layer_hit     = hit_q;
  assign frame_hits    = frame_hits_q;
  assign frame_hit_cnt = frame_cnt_q;
  assign frame_valid   = frame_valid_q;

endmodule

// File: tb/tb_draw_layer_arbiter.sv
// Self-checking bench for draw_layer_arbiter: a behavioural reference model
// queues the expected registered outputs per cycle, a monitor compares them on
// the falling edge, and scenario tasks add targeted checks.
module tb_draw_layer_arbiter;

  localparam int NL = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          startOfFrame = 1'b0;
  logic [NL-1:0] layer_req = '0;
  logic [NL*8-1:0] layer_rgb = '0;
  logic [NL-1:0] layer_en = '1;
  logic [7:0]    BG_RGB = 8'h03;
  logic          boardersDrawReq = 1'b0;

  logic [7:0]    RGBOut, RGBOut4;
  logic [NL-1:0] layer_hit, layer_hit4, frame_hits, frame_hits4;
  logic [15:0]   frame_hit_cnt;
  logic [3:0]    frame_hit_cnt4;
  logic          frame_valid, frame_valid4;

  draw_layer_arbiter #(.NUM_LAYERS(NL), .TRANSPARENT(8'hFF), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .layer_req(layer_req), .layer_rgb(layer_rgb), .layer_en(layer_en),
    .BG_RGB(BG_RGB), .boardersDrawReq(boardersDrawReq),
    .RGBOut(RGBOut), .layer_hit(layer_hit), .frame_hits(frame_hits),
    .frame_hit_cnt(frame_hit_cnt), .frame_valid(frame_valid));

  draw_layer_arbiter #(.NUM_LAYERS(NL), .TRANSPARENT(8'hFF), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .layer_req(layer_req), .layer_rgb(layer_rgb), .layer_en(layer_en),
    .BG_RGB(BG_RGB), .boardersDrawReq(boardersDrawReq),
    .RGBOut(RGBOut4), .layer_hit(layer_hit4), .frame_hits(frame_hits4),
    .frame_hit_cnt(frame_hit_cnt4), .frame_valid(frame_valid4));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          tag;
    logic [7:0]  rgb;
    logic [NL-1:0] hit;
    logic        fv;
    logic [NL-1:0] fh;
    int          fc;
    int          fc4;
  } exp_t;

  exp_t sb[$];

  // Reference model state.
  logic [NL-1:0] m_flags = '0;
  int m_cnt = 0, m_cnt4 = 0;
  logic [NL-1:0] m_fh = '0;
  int m_fc = 0, m_fc4 = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Evaluate the model on the present inputs, queue the result, advance a cycle.
  task automatic tick();
    exp_t e;
    logic [NL-1:0] eff;
    int n;
    logic found;
    eff = '0; n = 0; found = 1'b0;
    e.tag = cyc + 1;
    e.rgb = BG_RGB;
    for (int i = 0; i < NL; i++) begin
      logic [7:0] c;
      c = layer_rgb[i*8 +: 8];
      if (layer_req[i] && layer_en[i] && c != 8'hFF) begin
        eff[i] = 1'b1;
        n++;
        if (!found) begin e.rgb = c; found = 1'b1; end
      end
    end
    e.hit = (n >= 2 || boardersDrawReq) ? eff : '0;
    if (reset) begin
      e.rgb = 0; e.hit = 0; e.fv = 0;
      m_flags = 0; m_cnt = 0; m_cnt4 = 0; m_fh = 0; m_fc = 0; m_fc4 = 0;
    end else if (startOfFrame) begin
      m_fh = m_flags; m_fc = m_cnt; m_fc4 = m_cnt4;
      m_flags = e.hit;
      m_cnt = (e.hit != 0) ? 1 : 0;
      m_cnt4 = m_cnt;
      e.fv = 1;
    end else begin
      m_flags = m_flags | e.hit;
      if (e.hit != 0) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      e.fv = 0;
    end
    e.fh = m_fh; e.fc = m_fc; e.fc4 = m_fc4;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].tag == cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (RGBOut !== e.rgb || layer_hit !== e.hit || frame_valid !== e.fv ||
          frame_hits !== e.fh || frame_hit_cnt !== 16'(e.fc)) begin
        errors++;
        $display("FAIL sb cyc=%0d got rgb=%h hit=%b fv=%b fh=%b fc=%0d exp rgb=%h hit=%b fv=%b fh=%b fc=%0d",
                 cyc, RGBOut, layer_hit, frame_valid, frame_hits, frame_hit_cnt,
                 e.rgb, e.hit, e.fv, e.fh, e.fc);
      end
      checks++;
      if (RGBOut4 !== e.rgb || layer_hit4 !== e.hit || frame_valid4 !== e.fv ||
          frame_hits4 !== e.fh || frame_hit_cnt4 !== 4'(e.fc4)) begin
        errors++;
        $display("FAIL sb4 cyc=%0d got rgb=%h hit=%b fv=%b fh=%b fc=%0d exp rgb=%h hit=%b fv=%b fh=%b fc=%0d",
                 cyc, RGBOut4, layer_hit4, frame_valid4, frame_hits4, frame_hit_cnt4,
                 e.rgb, e.hit, e.fv, e.fh, e.fc4);
      end
    end
  end

  task automatic idle();
    layer_req = '0; boardersDrawReq = 1'b0; startOfFrame = 1'b0; layer_en = '1;
  endtask

  task automatic test_reset();
    reset = 1'b1; layer_req = '1;
    layer_rgb = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 2; i++) begin
      startOfFrame = (i == 1);
      tick();
      checks++;
      if (RGBOut !== 8'h00 || layer_hit !== '0 || frame_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs got rgb=%h hit=%b fv=%b exp 00/0000/0", RGBOut, layer_hit, frame_valid);
      end
    end
    reset = 1'b0; idle(); layer_req = 4'b0001;
    tick();
    checks++;
    if (RGBOut !== 8'h11) begin
      errors++; $display("FAIL reset_release got rgb=%h exp 11", RGBOut);
    end
  endtask

  task automatic test_priority();
    idle();
    layer_req = 4'b0110; layer_rgb = {8'h00, 8'hE0, 8'h1C, 8'h00}; BG_RGB = 8'h03;
    tick();
    checks++;
    if (RGBOut !== 8'h1C || layer_hit !== 4'b0110) begin
      errors++; $display("FAIL prio_overlap got rgb=%h hit=%b exp 1c/0110", RGBOut, layer_hit);
    end
    layer_req = '0;
    tick();
    checks++;
    if (RGBOut !== 8'h03 || layer_hit !== 4'b0000) begin
      errors++; $display("FAIL prio_bg got rgb=%h hit=%b exp 03/0000", RGBOut, layer_hit);
    end
    for (int i = 0; i < 6; i++) begin
      layer_req = 4'($urandom_range(0, 15));
      layer_en = 4'($urandom_range(0, 15));
      layer_rgb = {8'($urandom), 8'hFF, 8'($urandom), 8'($urandom)};
      boardersDrawReq = 1'($urandom);
      tick();
    end
    idle();
  endtask

  task automatic test_transparent_enable();
    idle();
    layer_req = 4'b0011; layer_rgb = {8'h00, 8'h00, 8'h55, 8'hFF};
    tick();
    checks++;
    if (RGBOut !== 8'h55 || layer_hit !== 4'b0000) begin
      errors++; $display("FAIL transparent got rgb=%h hit=%b exp 55/0000", RGBOut, layer_hit);
    end
    layer_en = 4'b1101; layer_rgb = {8'h00, 8'h00, 8'h55, 8'h20};
    tick();
    checks++;
    if (RGBOut !== 8'h20 || layer_hit !== 4'b0000) begin
      errors++; $display("FAIL disabled got rgb=%h hit=%b exp 20/0000", RGBOut, layer_hit);
    end
    idle();
  endtask

  task automatic test_frame_accum();
    idle(); startOfFrame = 1'b1; tick(); idle();
    layer_req = 4'b1000; layer_rgb = {8'h44, 24'h0}; boardersDrawReq = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    idle(); tick(); tick();
    startOfFrame = 1'b1; tick();
    checks++;
    if (frame_valid !== 1'b1 || frame_hits !== 4'b1000 || frame_hit_cnt !== 16'd5) begin
      errors++; $display("FAIL frame_publish got fv=%b fh=%b fc=%0d exp 1/1000/5", frame_valid, frame_hits, frame_hit_cnt);
    end
    idle(); tick();
    checks++;
    if (frame_valid !== 1'b0 || frame_hits !== 4'b1000 || frame_hit_cnt !== 16'd5) begin
      errors++; $display("FAIL frame_hold got fv=%b fh=%b fc=%0d exp 0/1000/5", frame_valid, frame_hits, frame_hit_cnt);
    end
    tick(); tick();
    startOfFrame = 1'b1; tick();
    checks++;
    if (frame_valid !== 1'b1 || frame_hits !== 4'b0000 || frame_hit_cnt !== 16'd0) begin
      errors++; $display("FAIL frame_empty got fv=%b fh=%b fc=%0d exp 1/0000/0", frame_valid, frame_hits, frame_hit_cnt);
    end
    idle();
  endtask

  task automatic test_saturation();
    idle(); startOfFrame = 1'b1; tick(); idle();
    layer_req = 4'b0011; layer_rgb = {16'h0, 8'h02, 8'h01};
    for (int i = 0; i < 20; i++) tick();
    idle(); startOfFrame = 1'b1; tick();
    checks++;
    if (frame_hit_cnt4 !== 4'd15 || frame_hit_cnt !== 16'd20 || frame_hits4 !== 4'b0011) begin
      errors++; $display("FAIL saturate got cnt4=%0d cnt16=%0d fh4=%b exp 15/20/0011", frame_hit_cnt4, frame_hit_cnt, frame_hits4);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    idle();
    // Frame opens with a layer-2 border hit so its accumulator holds 0100.
    startOfFrame = 1'b1; layer_req = 4'b0100; layer_rgb = {8'h0, 8'h30, 16'h0}; boardersDrawReq = 1'b1;
    tick(); idle(); tick();
    // Boundary coincides with a layer0/layer1 overlap.
    startOfFrame = 1'b1; layer_req = 4'b0011; layer_rgb = {16'h0, 8'h02, 8'h01};
    tick();
    checks++;
    if (frame_hits !== 4'b0100 || frame_valid !== 1'b1) begin
      errors++; $display("FAIL coincident_sof got fh=%b fv=%b exp 0100/1", frame_hits, frame_valid);
    end
    // Immediately following pulse publishes only the previous pulse cycle's hits.
    idle(); startOfFrame = 1'b1;
    tick();
    checks++;
    if (frame_hits !== 4'b0011 || frame_hit_cnt !== 16'd1 || frame_valid !== 1'b1) begin
      errors++; $display("FAIL back_to_back got fh=%b fc=%0d fv=%b exp 0011/1/1", frame_hits, frame_hit_cnt, frame_valid);
    end
    idle(); tick();
  endtask

  task automatic test_reset_midframe();
    idle(); startOfFrame = 1'b1; tick(); idle();
    layer_req = 4'b0011; layer_rgb = {16'h0, 8'h02, 8'h01};
    for (int i = 0; i < 3; i++) tick();
    idle(); reset = 1'b1; tick(); reset = 1'b0;
    tick(); tick();
    startOfFrame = 1'b1; tick();
    checks++;
    if (frame_hit_cnt !== 16'd0 || frame_hits !== 4'b0000 || frame_valid !== 1'b1) begin
      errors++; $display("FAIL reset_midframe got fc=%0d fh=%b fv=%b exp 0/0000/1", frame_hit_cnt, frame_hits, frame_valid);
    end
    idle(); tick();
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_priority();
    test_transparent_enable();
    test_frame_accum();
    test_saturation();
    test_back_to_back();
    test_reset_midframe();
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain got %0d pending exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
